// File: rtl/config_dispatcher_if.sv
// Shared UART receive/transmit handshakes plus the per-slot subsystem bus.
// The dispatcher uses the master side; the subsystems and UART sit on the slave side.
interface config_dispatcher_if #(
   parameter int N_SLOTS = 4
) ();
   logic               uart_rx_done;
   logic [7:0]         uart_rx_data;
   logic [N_SLOTS-1:0] sub_enable;
   logic [N_SLOTS-1:0] sub_rx_done;
   logic [7:0]         sub_rx_data;
   logic [N_SLOTS-1:0] sub_error;
   logic               tx_busy;
   logic               tx_start;
   logic [7:0]         tx_data;

   modport master (
      input  uart_rx_done, uart_rx_data, sub_error, tx_busy,
      output sub_enable, sub_rx_done, sub_rx_data, tx_start, tx_data
   );

   modport slave (
      output uart_rx_done, uart_rx_data, sub_error, tx_busy,
      input  sub_enable, sub_rx_done, sub_rx_data, tx_start, tx_data
   );
endinterface

// File: rtl/config_dispatcher.sv
// Routes a UART command session ('A'+slot, digits, CR) to one subsystem and answers with a status byte.
// Forwarded bytes lag the rx strobe by one cycle; bytes arriving while settling/releasing/responding are dropped and counted.
module config_dispatcher #(
   parameter int  N_SLOTS     = 4,
   parameter int  CLK_FREQ    = 100_000_000,
   parameter int  SETTLE_CNT  = CLK_FREQ / 1000,
   parameter int  SESSION_CNT = CLK_FREQ / 100,
   localparam int SLOT_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   config_dispatcher_if.master bus,
   output logic                o_busy,
   output logic [SLOT_W-1:0]   o_active_slot,
   output logic [7:0]          o_drop_cnt
);
   localparam int SESS_W = (SESSION_CNT > 1) ? $clog2(SESSION_CNT) : 1;
   localparam int SET_W  = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
   localparam logic [SESS_W-1:0] SESS_LAST = SESS_W'(SESSION_CNT - 1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CNT - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COLLECT = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;

   localparam logic [7:0] CH_K  = 8'h4B;
   localparam logic [7:0] CH_E  = 8'h45;
   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_Q  = 8'h3F;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_A  = 8'h41;

   logic [2:0]         r_state;
   logic [SLOT_W-1:0]  r_slot;
   logic [SESS_W-1:0]  r_sess_cnt;
   logic [SET_W-1:0]   r_settle_cnt;
   logic [1:0]         r_digit_cnt;
   logic               r_rel_cnt;
   logic [7:0]         r_resp;
   logic [N_SLOTS-1:0] r_sub_enable;
   logic [N_SLOTS-1:0] r_sub_rx_done;
   logic [7:0]         r_sub_rx_data;
   logic               r_tx_start;
   logic [7:0]         r_tx_data;
   logic [7:0]         r_drop_cnt;

   logic [7:0]        w_sel_off;
   logic [SLOT_W-1:0] w_sel_slot;
   logic              w_is_sel;
   logic              w_is_cr;
   logic              w_is_digit;
   logic              w_drop;

   assign w_sel_off  = bus.uart_rx_data - CH_A;
   assign w_sel_slot = w_sel_off[SLOT_W-1:0];
   assign w_is_sel   = (bus.uart_rx_data >= CH_A) && (w_sel_off < 8'(N_SLOTS));
   assign w_is_cr    = (bus.uart_rx_data == CH_CR);
   assign w_is_digit = (bus.uart_rx_data >= 8'h30) && (bus.uart_rx_data <= 8'h39);
   assign w_drop     = bus.uart_rx_done &&
                       (r_state == ST_SETTLE || r_state == ST_RELEASE || r_state == ST_RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_slot        <= '0;
         r_sess_cnt    <= '0;
         r_settle_cnt  <= '0;
         r_digit_cnt   <= '0;
         r_rel_cnt     <= 1'b0;
         r_resp        <= '0;
         r_sub_enable  <= '0;
         r_sub_rx_done <= '0;
         r_sub_rx_data <= '0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_sub_rx_done <= '0;
         r_tx_start    <= 1'b0;
         if (w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;

         case (r_state)
            ST_IDLE: begin
               if (bus.uart_rx_done) begin
                  if (w_is_sel) begin
                     r_slot       <= w_sel_slot;
                     r_sub_enable <= N_SLOTS'(1) << w_sel_slot;
                     r_sess_cnt   <= '0;
                     r_digit_cnt  <= '0;
                     r_state      <= ST_COLLECT;
                  end else begin
                     r_resp  <= CH_Q;
                     r_state <= ST_RESP;
                  end
               end
            end
            ST_COLLECT: begin
               r_sess_cnt <= r_sess_cnt + SESS_W'(1);
               // Timeout outranks a byte landing on the same cycle.
               if (r_sess_cnt == SESS_LAST) begin
                  r_resp       <= CH_T;
                  r_sub_enable <= '0;
                  r_rel_cnt    <= 1'b0;
                  r_state      <= ST_RELEASE;
               end else if (bus.uart_rx_done) begin
                  if (w_is_cr && r_digit_cnt != 2'd0) begin
                     r_settle_cnt <= '0;
                     r_state      <= ST_SETTLE;
                  end else if (w_is_cr || (w_is_digit && r_digit_cnt == 2'd2)) begin
                     r_resp       <= CH_E;
                     r_sub_enable <= '0;
                     r_rel_cnt    <= 1'b0;
                     r_state      <= ST_RELEASE;
                  end else begin
                     r_sub_rx_data         <= bus.uart_rx_data;
                     r_sub_rx_done[r_slot] <= 1'b1;
                     if (w_is_digit)
                        r_digit_cnt <= r_digit_cnt + 2'd1;
                  end
               end
            end
            ST_SETTLE: begin
               r_settle_cnt <= r_settle_cnt + SET_W'(1);
               if (r_settle_cnt == SET_LAST) begin
                  r_resp       <= bus.sub_error[r_slot] ? CH_E : CH_K;
                  r_sub_enable <= '0;
                  r_rel_cnt    <= 1'b0;
                  r_state      <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               r_rel_cnt <= 1'b1;
               if (r_rel_cnt)
                  r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (!bus.tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= r_resp;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.sub_enable  = r_sub_enable;
   assign bus.sub_rx_done = r_sub_rx_done;
   assign bus.sub_rx_data = r_sub_rx_data;
   assign bus.tx_start    = r_tx_start;
   assign bus.tx_data     = r_tx_data;
   assign o_busy          = (r_state != ST_IDLE);
   assign o_active_slot   = r_slot;
   assign o_drop_cnt      = r_drop_cnt;
endmodule

// File: doc/config_dispatcher.md
Name: config_dispatcher

Overview:
- Command front end that shares the single UART receive stream between N_SLOTS parameter-setting subsystems.
- Parses a one-letter slot selector, enables only the selected subsystem, and forwards its digit bytes to it.
- Waits for the subsystem to settle, samples its error flag, then releases it.
- Returns a one-byte status response through the UART transmitter handshake.

Parameters:
- N_SLOTS, 4, number of setting subsystems; slot i is selected by ASCII 'A'+i (0x41+i).
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- SETTLE_CNT, CLK_FREQ/1000, cycles to wait after terminator before sampling error (1 ms, greater than the 0.5 ms subsystem digit timeout).
- SESSION_CNT, CLK_FREQ/100, maximum cycles from selector to terminator (10 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx_done  in  1  one-cycle strobe, byte received.
- uart_rx_data  in  8  received byte, valid with uart_rx_done.
- sub_enable  out  N_SLOTS  one-hot enable per subsystem.
- sub_rx_done  out  N_SLOTS  gated receive strobe per subsystem.
- sub_rx_data  out  8  shared forwarded byte.
- sub_error  in  N_SLOTS  per-subsystem param_error.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  response byte.
- busy  out  1  high whenever state != IDLE.
- active_slot  out  $clog2(N_SLOTS)  selected slot; holds its last value in IDLE.
- drop_cnt  out  8  saturating count of bytes discarded in SETTLE, RELEASE and RESP.

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Counters and digit_cnt cleared. Reset mid-session drops sub_enable immediately and does not send a response.
- Response codes: 'K' = 0x4B, 'E' = 0x45, 'T' = 0x54, '?' = 0x3F. CR = 0x0D terminates a session.
- IDLE:
  - Byte in 0x41..0x41+N_SLOTS-1: latch slot = byte-0x41, set sub_enable[slot], clear the session counter and digit_cnt, go to COLLECT. sub_enable rises the cycle after the strobe.
  - Any other byte: resp='?', go to RESP (no subsystem is enabled).
- COLLECT (sub_enable[slot]=1; the session counter increments every cycle):
  - Non-CR byte: forward it. sub_rx_data and sub_rx_done[slot] are registered, so latency is exactly 1 cycle and the strobe is 1 cycle wide. Digits ('0'..'9') increment digit_cnt.
  - Third digit: not forwarded; resp='E', go to RELEASE.
  - Non-digit, non-CR bytes are forwarded and not counted.
  - CR with digit_cnt=0: resp='E', go to RELEASE. CR is never forwarded.
  - CR with digit_cnt 1 or 2: clear the settle counter, go to SETTLE.
  - Session counter reaches SESSION_CNT-1 with no CR: resp='T', go to RELEASE.
  - If a byte arrives on the same cycle as the session timeout, the timeout wins and the byte is not forwarded.
- SETTLE (enable held): count to SETTLE_CNT-1. On the final cycle sample sub_error[slot]: 1 gives resp='E', 0 gives resp='K'. Go to RELEASE.
- RELEASE: sub_enable=0 for exactly 2 cycles, which returns the subsystem to its idle state. Then go to RESP.
- RESP: wait while tx_busy=1. When tx_busy=0, drive tx_data=resp and pulse tx_start for 1 cycle, then go to IDLE.
- Dropped bytes: any uart_rx_done in SETTLE, RELEASE or RESP is discarded and increments drop_cnt, saturating at 255. An IDLE strobe on the same cycle as the RESP→IDLE transition is not seen and is counted as dropped.
- Only one sub_enable bit and at most one sub_rx_done bit are ever high; all are zero outside COLLECT and SETTLE.
- Counters are wide enough for SESSION_CNT and SETTLE_CNT; width is derived with $clog2.

Test Plan (bench overrides SETTLE_CNT=50, SESSION_CNT=500):
- Bytes 'B','2','5',CR; sub_error=0 → sub_enable=4'b0010, two sub_rx_done[1] pulses carrying 0x32 and 0x35 one cycle after each strobe, no CR forwarded, enable drops 50 cycles after CR, tx_data=0x4B with one tx_start pulse.
- Bytes 'A','3',CR; model drives sub_error[0]=1 during SETTLE → response 0x45; sub_enable low for 2 cycles before tx_start.
- Byte 'Z' in IDLE → tx_data=0x3F; sub_enable stays 0.
- Bytes 'C','1' with no CR → tx_data=0x54 after 500 cycles; enable released.
- Bytes 'D','1','2','3' → third digit not forwarded, response 0x45. Separately, 'A',CR → 0x45 with no SETTLE.
- tx_busy held high 100 cycles in RESP while 3 bytes arrive → tx_start is issued only after tx_busy falls, drop_cnt=3; assert rst_n low during COLLECT → all outputs 0 on the next edge.
